// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, one-hot ALU op encodings and writeback-bus type for the
// MIPS execute front end.
//   DATA_W / REG_AW / OP_W / SA_W : datapath, register-index, ALU-op and shamt widths
//   OP_*                          : one-hot ALU op constants, OP_NOP = 0 (bubble)
//   wb_bus_t                      : {write enable, destination index, result}
//   fwd_hit()                     : true when a writeback bus produces register idx
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 11;
    localparam int unsigned SA_W   = 5;

    localparam logic [OP_W-1:0] OP_NOP = 11'b000_0000_0000;
    localparam logic [OP_W-1:0] OP_ADD = 11'b000_0000_0001;
    localparam logic [OP_W-1:0] OP_SUB = 11'b000_0000_0010;
    localparam logic [OP_W-1:0] OP_AND = 11'b000_0000_0100;
    localparam logic [OP_W-1:0] OP_OR  = 11'b000_0000_1000;
    localparam logic [OP_W-1:0] OP_XOR = 11'b000_0001_0000;
    localparam logic [OP_W-1:0] OP_NOR = 11'b000_0010_0000;
    localparam logic [OP_W-1:0] OP_SLT = 11'b000_0100_0000;
    localparam logic [OP_W-1:0] OP_LUI = 11'b000_1000_0000;
    localparam logic [OP_W-1:0] OP_SRA = 11'b001_0000_0000;
    localparam logic [OP_W-1:0] OP_SRL = 11'b010_0000_0000;
    localparam logic [OP_W-1:0] OP_SLL = 11'b100_0000_0000;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_bus_t;

    // r0 is hard-wired to zero, so a write to it must never be forwarded.
    function automatic logic fwd_hit(input logic              we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] idx);
        return we && (rd == idx) && (idx != '0);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: per-operand RAW bypass. Selects the youngest in-flight result for register
// i_idx: EX/MEM first, then MEM/WB, otherwise the value stored in the ID/EX register.
// Ports:
//   i_idx    : source register index held in ID/EX
//   i_stored : value captured in ID/EX for that register
//   i_mem    : EX/MEM writeback bus
//   i_wb     : MEM/WB writeback bus
//   o_fwd    : operand value to present to the ALU
// Build option EX_FORWARD_EN: when undefined the mux collapses to i_stored.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [REG_AW-1:0] i_idx,
    input  logic [DATA_W-1:0] i_stored,
    input  wb_bus_t           i_mem,
    input  wb_bus_t           i_wb,
    output logic [DATA_W-1:0] o_fwd
);

`ifdef EX_FORWARD_EN
    always_comb begin
        o_fwd = i_stored;
        if (fwd_hit(i_mem.we, i_mem.rd, i_idx)) begin
            o_fwd = i_mem.data;
        end else if (fwd_hit(i_wb.we, i_wb.rd, i_idx)) begin
            o_fwd = i_wb.data;
        end
    end
`else
    assign o_fwd = i_stored;

    logic w_unused;
    assign w_unused = ^{i_idx, i_mem, i_wb};
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register plus operand forwarding feeding the ALU.
// Ports:
//   clk, reset                : rising-edge clock, asynchronous active-high reset
//   id_*                      : decoded instruction fields from ID
//   stall, flush              : hold stage / insert bubble (flush wins)
//   mem_*, wb_*               : EX/MEM and MEM/WB writeback buses
//   alu_a/alu_b/alu_op/alu_sa : ALU inputs
//   ex_valid/ex_reg_write/ex_rd/ex_store_data : fields passed on to MEM
// Build option EX_FORWARD_EN: enables MEM/WB forwarding and the stall re-latch of the
// stored operands. The WB capture bypass is present in both builds.
module ex_operand_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic [SA_W-1:0]   id_sa,
    input  logic              id_var_sa,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [SA_W-1:0]   alu_sa,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_store_data
);

    logic              r_valid;
    logic              r_reg_write;
    logic [OP_W-1:0]   r_alu_op;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [DATA_W-1:0] r_rs_val;
    logic [DATA_W-1:0] r_rt_val;
    logic [DATA_W-1:0] r_imm;
    logic              r_use_imm;
    logic [SA_W-1:0]   r_sa;
    logic              r_var_sa;
    logic [REG_AW-1:0] r_rd;

    wb_bus_t           w_mem_bus;
    wb_bus_t           w_wb_bus;
    logic [DATA_W-1:0] w_cap_rs_val;
    logic [DATA_W-1:0] w_cap_rt_val;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    assign w_mem_bus = {mem_reg_write, mem_rd, mem_result};
    assign w_wb_bus  = {wb_reg_write, wb_rd, wb_result};

    // The register file writes at the end of the cycle it is read, so a WB producer
    // of the same register is not yet visible in id_*_val.
    assign w_cap_rs_val = fwd_hit(wb_reg_write, wb_rd, id_rs) ? wb_result : id_rs_val;
    assign w_cap_rt_val = fwd_hit(wb_reg_write, wb_rd, id_rt) ? wb_result : id_rt_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_alu_op    <= OP_NOP;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rs_val    <= '0;
            r_rt_val    <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_sa        <= '0;
            r_var_sa    <= 1'b0;
            r_rd        <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_alu_op    <= OP_NOP;
        end else if (stall) begin
`ifdef EX_FORWARD_EN
            // A producer may leave WB while we wait; keep its value.
            r_rs_val <= w_fwd_rs;
            r_rt_val <= w_fwd_rt;
`endif
        end else begin
            r_valid     <= id_valid;
            r_reg_write <= id_valid & id_reg_write;
            r_alu_op    <= id_valid ? id_alu_op : OP_NOP;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_rs_val    <= w_cap_rs_val;
            r_rt_val    <= w_cap_rt_val;
            r_imm       <= id_imm;
            r_use_imm   <= id_use_imm;
            r_sa        <= id_sa;
            r_var_sa    <= id_var_sa;
            r_rd        <= id_rd;
        end
    end

    fwd_mux u_fwd_rs (
        .i_idx    (r_rs),
        .i_stored (r_rs_val),
        .i_mem    (w_mem_bus),
        .i_wb     (w_wb_bus),
        .o_fwd    (w_fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .i_idx    (r_rt),
        .i_stored (r_rt_val),
        .i_mem    (w_mem_bus),
        .i_wb     (w_wb_bus),
        .o_fwd    (w_fwd_rt)
    );

    assign alu_a         = w_fwd_rs;
    assign alu_b         = r_use_imm ? r_imm : w_fwd_rt;
    assign alu_op        = r_alu_op;
    assign alu_sa        = r_var_sa ? w_fwd_rs[SA_W-1:0] : r_sa;
    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_rd         = r_rd;
    assign ex_store_data = w_fwd_rt;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding stage sitting directly upstream of the MIPS execute ALU. It captures decoded instruction fields from ID. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results. It drives the ALU's a, b, op and sa inputs, plus the destination and store-data fields passed on to MEM.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register index width
OP_W, 11, one-hot ALU op width (bit0 ADD … bit10 SLL)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs, id_rt  in  REG_AW each  source register indices
id_rs_val, id_rt_val  in  DATA_W each  register-file read data
id_imm  in  DATA_W  pre-extended immediate
id_use_imm  in  1  b operand = immediate instead of rt
id_alu_op  in  OP_W  one-hot ALU op
id_sa  in  5  shamt field
id_var_sa  in  1  shift amount = rs[4:0] (SLLV/SRLV/SRAV)
id_rd  in  REG_AW  destination index
id_reg_write  in  1  instruction writes rd
stall  in  1  hold stage contents
flush  in  1  insert bubble
mem_reg_write, mem_rd, mem_result  in  1/REG_AW/DATA_W  EX/MEM writeback bus
wb_reg_write, wb_rd, wb_result  in  1/REG_AW/DATA_W  MEM/WB writeback bus
alu_a, alu_b  out  DATA_W each  ALU operands
alu_op  out  OP_W  ALU op
alu_sa  out  5  ALU shift amount
ex_valid, ex_reg_write  out  1 each  qualifiers to MEM
ex_rd  out  REG_AW  destination to MEM
ex_store_data  out  DATA_W  forwarded rt value for SW

Behaviour:
- Reset (async, immediate): all registers 0. ex_valid=0, ex_reg_write=0, alu_op=0 (ALU outputs 0), alu_a=alu_b=0, alu_sa=0.
- Priority each rising edge: reset > flush > stall > load.
- Load (!stall, !flush): capture all id_* fields. Latency 1 cycle ID->ALU inputs.
- WB bypass at capture: if wb_reg_write and wb_rd==id_rs and id_rs!=0, the captured rs value is wb_result, not id_rs_val. The same rule applies to rt. This covers register-file write/read in the same cycle.
- Flush: ex_valid, ex_reg_write and alu_op cleared to 0. Other fields are don't-care. Flush during stall still clears.
- Stall: indices and control held. Stored rs/rt values are re-latched with the current forwarded values, so a producer leaving WB during the stall is not lost.
- Forwarding (combinational on stored values), per operand rs/rt:
  - If mem_reg_write, mem_rd==idx and idx!=0, select mem_result.
  - Else if wb_reg_write, wb_rd==idx and idx!=0, select wb_result.
  - Else use the stored value.
  - MEM has priority over WB when both match. Register 0 is never forwarded and is always read as the stored value.
- alu_a = fwd_rs.
- alu_b = stored imm if use_imm, else fwd_rt.
- ex_store_data = fwd_rt, always.
- alu_sa = fwd_rs[4:0] if var_sa, else stored sa. Shift ops use b as the shifted value.
- id_valid=0 on load: ex_valid=0 and alu_op=0, same as a bubble.
- Load-use hazard (load in EX) is not detected here. The upstream hazard unit asserts stall.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: MEM/WB forwarding muxes and the stall re-latch are present, as above.
- Undefined: forwarding logic is removed. Operands come straight from the stored values, and the stall re-latch is omitted. The WB capture bypass remains. The hazard unit must stall until producers retire.

Decomposition:
- Shared package/header mips_pkg:
  - one-hot ALU op constants (ADD…SLL)
  - OP_W, DATA_W, REG_AW
  - NOP op value 0
- One sub-module, fwd_mux: index, stored value and both writeback buses in; forwarded value out. It is instantiated twice (rs, rt).

Test Plan:
- Reset mid-operation: load ADD r1,r2,r3, then assert reset between edges. Outputs go to 0 immediately, and ex_valid=0 before the next edge.
- Basic ADDI: id_rs=2 (val 0x10), imm 0x5, use_imm, op ADD. Next cycle alu_a=0x10, alu_b=0x5, alu_op=ADD.
- Double match: mem_rd=wb_rd=3, rs=3, mem_result=0xAAAA, wb_result=0x5555. alu_a=0xAAAA. Repeat with mem_reg_write=0: alu_a=0x5555.
- Register zero: rs=0, mem_rd=0, mem_reg_write=1, mem_result=0xFFFF. alu_a stays the stored value 0.
- Stall re-latch: stall two cycles while WB writes r4=0x1234 in the first cycle only, with rt=4. alu_b stays 0x1234 in the second cycle.
- Flush+stall together: ex_valid=0 and alu_op=0 next cycle. SLLV with rs val 0x23 gives alu_sa=3.
